// File: rtl/wb_merge_queue.sv
// Writeback merge queue: accepts up to two register writebacks per cycle,
// buffers them in order, and drains one per cycle into the register file.
module wb_merge_queue #(
    parameter  int DEPTH        = 8,
    parameter  int ADDR_W       = 5,
    parameter  int DATA_W       = 16,
    parameter  int STALL_THRESH = DEPTH - 4,
    localparam int CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              wbEnableA_i,
    input  logic [ADDR_W-1:0] wbAddressA_i,
    input  logic [DATA_W-1:0] wbDataA_i,
    input  logic              wbEnableB_i,
    input  logic [ADDR_W-1:0] wbAddressB_i,
    input  logic [DATA_W-1:0] wbDataB_i,
    output logic              rfWriteEnable_o,
    output logic [ADDR_W-1:0] rfWriteAddress_o,
    output logic [DATA_W-1:0] rfWriteData_o,
    output logic              stall_o,
    output logic              overflow_o,
    output logic [CNT_W-1:0]  count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] addrMem [DEPTH];
    logic [DATA_W-1:0] dataMem [DEPTH];

    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] wrPtrB;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] countNext;
    logic [CNT_W:0]   freeSlots;
    logic             pop;
    logic             acceptA;
    logic             acceptB;
    logic             dropped;
    logic             overflow;

    // A slot vacated by this edge's pop is counted as free for this edge's push.
    always_comb begin
        pop       = (count != '0);
        freeSlots = (CNT_W + 1)'(DEPTH) - {1'b0, count} + {{CNT_W{1'b0}}, pop};
        acceptA   = wbEnableA_i && (freeSlots != '0);
        acceptB   = wbEnableB_i &&
                    (acceptA ? (freeSlots >= (CNT_W + 1)'(2)) : (freeSlots != '0));
        dropped   = (wbEnableA_i && !acceptA) || (wbEnableB_i && !acceptB);
        wrPtrB    = acceptA ? wrPtr + PTR_W'(1) : wrPtr;
        countNext = count - CNT_W'(pop) + CNT_W'(acceptA) + CNT_W'(acceptB);
    end

    // B lands directly behind A so register-file order follows port order.
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            if (acceptA) begin
                addrMem[wrPtr] <= wbAddressA_i;
                dataMem[wrPtr] <= wbDataA_i;
            end
            if (acceptB) begin
                addrMem[wrPtrB] <= wbAddressB_i;
                dataMem[wrPtrB] <= wbDataB_i;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            rdPtr            <= '0;
            wrPtr            <= '0;
            count            <= '0;
            overflow         <= 1'b0;
            rfWriteEnable_o  <= 1'b0;
            rfWriteAddress_o <= '0;
            rfWriteData_o    <= '0;
        end else begin
            rdPtr           <= rdPtr + PTR_W'(pop);
            wrPtr           <= wrPtr + PTR_W'(acceptA) + PTR_W'(acceptB);
            count           <= countNext;
            rfWriteEnable_o <= pop;
            if (dropped) begin
                overflow <= 1'b1;
            end
            if (pop) begin
                rfWriteAddress_o <= addrMem[rdPtr];
                rfWriteData_o    <= dataMem[rdPtr];
            end
        end
    end

    assign count_o    = count;
    assign overflow_o = overflow;
    assign stall_o    = (count >= CNT_W'(STALL_THRESH));

endmodule

// File: tb/tb_wb_merge_queue.sv
// Directed bench for wb_merge_queue: single/dual writes, idle inputs,
// fill with overflow, reset mid-operation and pointer wrap-around.
module tb_wb_merge_queue;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 4;

    logic              clock_i = 1'b0;
    logic              reset_i;
    logic              wbEnableA_i;
    logic [ADDR_W-1:0] wbAddressA_i;
    logic [DATA_W-1:0] wbDataA_i;
    logic              wbEnableB_i;
    logic [ADDR_W-1:0] wbAddressB_i;
    logic [DATA_W-1:0] wbDataB_i;
    logic              rfWriteEnable_o;
    logic [ADDR_W-1:0] rfWriteAddress_o;
    logic [DATA_W-1:0] rfWriteData_o;
    logic              stall_o;
    logic              overflow_o;
    logic [CNT_W-1:0]  count_o;

    always #5 clock_i = ~clock_i;

    wb_merge_queue #(
        .DEPTH(DEPTH),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .STALL_THRESH(DEPTH - 4)
    ) dut (
        .clock_i(clock_i),
        .reset_i(reset_i),
        .wbEnableA_i(wbEnableA_i),
        .wbAddressA_i(wbAddressA_i),
        .wbDataA_i(wbDataA_i),
        .wbEnableB_i(wbEnableB_i),
        .wbAddressB_i(wbAddressB_i),
        .wbDataB_i(wbDataB_i),
        .rfWriteEnable_o(rfWriteEnable_o),
        .rfWriteAddress_o(rfWriteAddress_o),
        .rfWriteData_o(rfWriteData_o),
        .stall_o(stall_o),
        .overflow_o(overflow_o),
        .count_o(count_o)
    );

    int checks   = 0;
    int failures = 0;

    logic [ADDR_W+DATA_W-1:0] expQ [$];
    logic [ADDR_W-1:0]        lastAddr;
    logic [DATA_W-1:0]        lastData;
    logic                     expOverflow;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, state which ones the queue should accept, check after the edge.
    task automatic step(input logic eA, input logic [ADDR_W-1:0] aA, input logic [DATA_W-1:0] dA,
                        input logic eB, input logic [ADDR_W-1:0] aB, input logic [DATA_W-1:0] dB,
                        input logic accA, input logic accB, input string tag);
        logic                     expPop;
        logic [ADDR_W+DATA_W-1:0] head;
        wbEnableA_i  = eA;
        wbAddressA_i = aA;
        wbDataA_i    = dA;
        wbEnableB_i  = eB;
        wbAddressB_i = aB;
        wbDataB_i    = dB;
        expPop = (expQ.size() != 0);
        if (expPop) begin
            head     = expQ.pop_front();
            lastAddr = head[ADDR_W+DATA_W-1:DATA_W];
            lastData = head[DATA_W-1:0];
        end
        if (accA) expQ.push_back({aA, dA});
        if (accB) expQ.push_back({aB, dB});
        if ((eA && !accA) || (eB && !accB)) expOverflow = 1'b1;
        @(posedge clock_i);
        #1;
        check({tag, " we"}, 32'(rfWriteEnable_o), 32'(expPop));
        check({tag, " addr"}, 32'(rfWriteAddress_o), 32'(lastAddr));
        check({tag, " data"}, 32'(rfWriteData_o), 32'(lastData));
        check({tag, " count"}, 32'(count_o), expQ.size());
        check({tag, " stall"}, 32'(stall_o), 32'(expQ.size() >= 4));
        check({tag, " overflow"}, 32'(overflow_o), 32'(expOverflow));
    endtask

    task automatic idle(input string tag);
        step(1'b0, 5'h1f, 16'hdead, 1'b0, 5'h15, 16'hbeef, 1'b0, 1'b0, tag);
    endtask

    // Reset with both ports valid: nothing from this cycle may be queued.
    task automatic doReset(input string tag);
        wbEnableA_i  = 1'b1;
        wbAddressA_i = 5'h07;
        wbDataA_i    = 16'h7777;
        wbEnableB_i  = 1'b1;
        wbAddressB_i = 5'h08;
        wbDataB_i    = 16'h8888;
        reset_i      = 1'b1;
        @(posedge clock_i);
        #1;
        reset_i     = 1'b0;
        wbEnableA_i = 1'b0;
        wbEnableB_i = 1'b0;
        expQ.delete();
        lastAddr    = '0;
        lastData    = '0;
        expOverflow = 1'b0;
        check({tag, " we"}, 32'(rfWriteEnable_o), 32'd0);
        check({tag, " addr"}, 32'(rfWriteAddress_o), 32'd0);
        check({tag, " data"}, 32'(rfWriteData_o), 32'd0);
        check({tag, " count"}, 32'(count_o), 32'd0);
        check({tag, " stall"}, 32'(stall_o), 32'd0);
        check({tag, " overflow"}, 32'(overflow_o), 32'd0);
    endtask

    initial begin
        reset_i      = 1'b1;
        wbEnableA_i  = 1'b0;
        wbAddressA_i = '0;
        wbDataA_i    = '0;
        wbEnableB_i  = 1'b0;
        wbAddressB_i = '0;
        wbDataB_i    = '0;
        @(posedge clock_i);
        #1;
        doReset("reset");

        // Single write: count 1 after edge 1, r3/0x1234 written in cycle 2.
        step(1'b1, 5'd3, 16'h1234, 1'b0, 5'd0, 16'h0000, 1'b1, 1'b0, "single push");
        check("single count1", 32'(count_o), 32'd1);
        idle("single pop");
        check("single we", 32'(rfWriteEnable_o), 32'd1);
        check("single addr", 32'(rfWriteAddress_o), 32'd3);
        check("single data", 32'(rfWriteData_o), 32'h1234);
        check("single count0", 32'(count_o), 32'd0);
        idle("single after");

        // Dual ordering: A before B.
        step(1'b1, 5'd1, 16'haaaa, 1'b1, 5'd2, 16'hbbbb, 1'b1, 1'b1, "dual push");
        idle("dual popA");
        check("dual first addr", 32'(rfWriteAddress_o), 32'd1);
        check("dual first data", 32'(rfWriteData_o), 32'haaaa);
        idle("dual popB");
        check("dual second addr", 32'(rfWriteAddress_o), 32'd2);
        check("dual second data", 32'(rfWriteData_o), 32'hbbbb);
        idle("dual after");

        // Idle inputs with nonzero address/data.
        for (int i = 0; i < 10; i++) idle("idle");

        // Fill: both ports every cycle; at edge 8 A is taken and B dropped.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 5'(2 * i), 16'h1000 + 16'(i), 1'b1, 5'(2 * i + 1), 16'h2000 + 16'(i),
                 1'b1, (i < 7), "fill");
            check("fill count", 32'(count_o), (i < 7) ? i + 2 : 8);
            if (i == 1) check("fill stall low", 32'(stall_o), 32'd0);
            if (i == 2) check("fill stall rise", 32'(stall_o), 32'd1);
            if (i == 6) check("fill overflow before", 32'(overflow_o), 32'd0);
        end
        check("fill overflow set", 32'(overflow_o), 32'd1);
        for (int i = 0; i < 9; i++) idle("fill drain");
        check("fill drained", 32'(count_o), 32'd0);
        check("fill sticky", 32'(overflow_o), 32'd1);

        // Build count 5 with overflow still set, then reset with both ports valid.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 5'(i), 16'h4000 + 16'(i), 1'b1, 5'(i + 8), 16'h5000 + 16'(i),
                 1'b1, 1'b1, "preReset");
        end
        check("preReset count", 32'(count_o), 32'd5);
        check("preReset overflow", 32'(overflow_o), 32'd1);
        doReset("midReset");
        for (int i = 0; i < 4; i++) idle("postReset");

        // Wrap: 6 pushed, 5 drained, then 6 more with a pair straddling slot 7 -> 0.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 5'(i), 16'h3000 + 16'(i), 1'b1, 5'(i + 16), 16'h3100 + 16'(i),
                 1'b1, 1'b1, "wrap push1");
        end
        for (int i = 0; i < 3; i++) idle("wrap drain1");
        check("wrap left one", 32'(count_o), 32'd1);
        step(1'b1, 5'd20, 16'h6000, 1'b0, 5'd0, 16'h0000, 1'b1, 1'b0, "wrap pushA");
        step(1'b1, 5'd21, 16'h6001, 1'b1, 5'd22, 16'h6002, 1'b1, 1'b1, "wrap straddle");
        step(1'b1, 5'd23, 16'h6003, 1'b1, 5'd24, 16'h6004, 1'b1, 1'b1, "wrap push2");
        step(1'b0, 5'd0, 16'h0000, 1'b1, 5'd25, 16'h6005, 1'b0, 1'b1, "wrap pushB");
        for (int i = 0; i < 5; i++) idle("wrap drain2");
        check("wrap last addr", 32'(rfWriteAddress_o), 32'd25);
        check("wrap last data", 32'(rfWriteData_o), 32'h6005);
        idle("wrap empty");
        check("wrap overflow", 32'(overflow_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/wb_merge_queue.md
# wb_merge_queue

Writeback merge queue between the dual-port load/store stage (L1 data cache) and the register file. Accepts up to two register writebacks per cycle (ports A and B), buffers them in an in-order FIFO, and drains one write per cycle into the register file's single write port. Signals back-pressure to the issue side before the buffer fills, and flags any lost writeback.

## Interface
- DEPTH, 8, FIFO entries; power of two, ≥ 4
- ADDR_W, 5, register address width
- DATA_W, 16, writeback data width
- STALL_THRESH, DEPTH-4, occupancy at or above which stall_o asserts; covers the upstream pipeline depth
- clock_i  in  1  single clock, rising edge
- reset_i  in  1  reset; synchronous, active-high
- wbEnableA_i  in  1  port A writeback valid
- wbAddressA_i  in  ADDR_W  port A destination register
- wbDataA_i  in  DATA_W  port A data
- wbEnableB_i  in  1  port B writeback valid
- wbAddressB_i  in  ADDR_W  port B destination register
- wbDataB_i  in  DATA_W  port B data
- rfWriteEnable_o  out  1  register file write strobe (registered)
- rfWriteAddress_o  out  ADDR_W  register file write address (registered)
- rfWriteData_o  out  DATA_W  register file write data (registered)
- stall_o  out  1  back-pressure to issue; high when count_o ≥ STALL_THRESH
- overflow_o  out  1  sticky; set when any valid writeback is dropped
- count_o  out  clog2(DEPTH+1)  current occupancy

## Operation
- Storage: DEPTH entries of {addr, data}, read pointer, write pointer, and an occupancy counter. Pointers wrap modulo DEPTH.
- At each edge, let C be the count before the edge.
- Pop: if C > 0, the head entry drives the rf outputs with rfWriteEnable_o = 1, and the read pointer advances. If C = 0, rfWriteEnable_o = 0 and address/data hold their previous values.
- Free slots for this edge: DEPTH − C + pop. A slot freed by a same-edge pop is reusable.
- Push: only inputs with enable = 1 are pushed. Address and data are ignored when enable = 0.
  - A is always placed before B, so within a cycle A precedes B in register-file write order.
  - If only one slot is free and both inputs are valid, A is accepted and B is dropped.
  - If zero slots are free, both are dropped.
- Any dropped valid input sets overflow_o = 1 at that edge. Only reset clears it.
- Count update: count_next = C − pop + pushes, range 0..DEPTH.
- Order is strictly FIFO. Same-address entries are neither merged nor filtered, so the later write lands last.
- Address 0 is not special-cased.
- stall_o is decoded from the count register (no input-to-output combinational path).

## Timing
- Reset: at a rising edge with reset_i = 1, the following clear to 0: count_o, both pointers, rfWriteEnable_o, rfWriteAddress_o, rfWriteData_o, overflow_o. stall_o also reads 0.
- Reset mid-operation discards all queued entries. Inputs sampled at the reset edge are not pushed.
- Latency: an input valid in cycle k is pushed at edge k+1. Into an empty queue, it is popped at edge k+2, so rfWriteEnable_o is high during cycle k+2. Minimum latency is 2 edges.
- Throughput: 1 write per cycle out; up to 2 accepted per cycle in.
- Full with simultaneous pop: at C = DEPTH, one slot frees, so exactly one input (A has priority) is accepted.
- Empty with simultaneous push: no pop at that edge, so the entry leaves one edge later. There is no bypass.
- Wrap-around: pointer rollover from DEPTH−1 to 0 is seamless. A two-entry push may straddle the rollover.

## Test plan
- Single write: A = {r3, 0x1234} valid in cycle 0 → count_o = 1 after edge 1; rfWriteEnable_o = 1, rfWriteAddress_o = 3, rfWriteData_o = 0x1234 during cycle 2; count_o = 0 after edge 2.
- Dual ordering: A = {r1, 0xAAAA} and B = {r2, 0xBBBB} in the same cycle 0 → r1/0xAAAA written in cycle 2, r2/0xBBBB in cycle 3. No overflow.
- Fill/overflow: both ports valid every cycle from empty, DEPTH = 8.
  - count_o reads n+1 after edge n.
  - stall_o rises after edge 3 (count 4).
  - count_o = 8 after edge 7.
  - At edge 8, A is accepted, B is dropped, overflow_o = 1, and count stays 8.
  - Every accepted entry later drains in order.
- Wrap-around: push 6 entries, drain 5, then push 6 more with distinct data → the output sequence matches push order exactly across the pointer rollover.
- Reset mid-operation: with count 5 and overflow_o = 1, assert reset_i for one edge while both inputs are valid → all outputs are 0 after that edge; nothing from the reset cycle appears on rfWriteEnable_o afterwards.
- Idle inputs: wbEnable low with nonzero address/data for 10 cycles → count_o stays 0 and rfWriteEnable_o stays 0.
